alu_serial_ctrl: RTL and testbench

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

---
 rtl/alu_serial_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial link controller for an external ALU: sends B, A and a command byte as
// framed 11-bit packets on sin, then collects the framed response from sout.
module alu_serial_ctrl #(
    parameter int GAP     = 1,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [7:0]  req_cmd,
    output logic        sin,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [7:0]  rsp_ctl,
    output logic        rsp_err,
    output logic        rsp_frame_err,
    output logic        rsp_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_TX, ST_GAP, ST_RX_WAIT, ST_RX_BIT, ST_DONE
    } state_t;

    localparam logic [3:0]  GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic [15:0] TMO_TC = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q, acc;
    logic [7:0]  cmd_q, tx_byte;
    logic [3:0]  pkt, bit_cnt, gap_cnt, rx_cnt;
    logic [15:0] tmo_cnt;
    logic [8:0]  rx_sh;
    logic [2:0]  rx_pkt;
    logic [10:0] frame;
    logic        accept, ld_rsp;
    logic [31:0] n_data;
    logic [7:0]  n_ctl;
    logic        n_err, n_ferr, n_tmo;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign rsp_valid = (state == ST_DONE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        tx_byte = 8'h00;
        case (pkt)
            4'd0: tx_byte = b_q[31:24];
            4'd1: tx_byte = b_q[23:16];
            4'd2: tx_byte = b_q[15:8];
            4'd3: tx_byte = b_q[7:0];
            4'd4: tx_byte = a_q[31:24];
            4'd5: tx_byte = a_q[23:16];
            4'd6: tx_byte = a_q[15:8];
            4'd7: tx_byte = a_q[7:0];
            4'd8: tx_byte = cmd_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // frame[10] is the start bit, sent first
    assign frame = {1'b0, (pkt == 4'd8), tx_byte, 1'b1};
    assign sin   = (state == ST_TX) ? frame[4'd10 - bit_cnt] : 1'b1;

    always_comb begin
        state_nxt = state;
        ld_rsp    = 1'b0;
        n_data    = 32'h0;
        n_ctl     = 8'h00;
        n_err     = 1'b0;
        n_ferr    = 1'b0;
        n_tmo     = 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_TX;
            ST_TX: begin
                if (bit_cnt == 4'd10) begin
                    if (pkt == 4'd8)   state_nxt = ST_RX_WAIT;
                    else if (GAP == 0) state_nxt = ST_TX;
                    else               state_nxt = ST_GAP;
                end
            end
            ST_GAP: if (gap_cnt == 4'd0) state_nxt = ST_TX;
            ST_RX_WAIT: begin
                if (!sout) begin
                    state_nxt = ST_RX_BIT;
                end else if (tmo_cnt == TMO_TC) begin
                    state_nxt = ST_DONE;
                    ld_rsp    = 1'b1;
                    n_tmo     = 1'b1;
                end
            end
            ST_RX_BIT: begin
                if (rx_cnt == 4'd9) begin
                    state_nxt = ST_DONE;
                    ld_rsp    = 1'b1;
                    if (!sout) begin
                        n_ferr = 1'b1;
                    end else if (rx_sh[8]) begin
                        if (rx_pkt == 3'd0) begin
                            n_err = 1'b1;
                            n_ctl = rx_sh[7:0];
                        end else if (rx_pkt == 3'd4) begin
                            n_data = acc;
                            n_ctl  = rx_sh[7:0];
                        end else begin
                            n_ferr = 1'b1;
                        end
                    end else if (rx_pkt == 3'd4) begin
                        n_ferr = 1'b1;
                    end else begin
                        state_nxt = ST_RX_WAIT;
                        ld_rsp    = 1'b0;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            cmd_q         <= 8'h00;
            pkt           <= 4'd0;
            bit_cnt       <= 4'd0;
            gap_cnt       <= 4'd0;
            tmo_cnt       <= 16'd0;
            rx_cnt        <= 4'd0;
            rx_sh         <= 9'h0;
            rx_pkt        <= 3'd0;
            acc           <= 32'h0;
            rsp_data      <= 32'h0;
            rsp_ctl       <= 8'h00;
            rsp_err       <= 1'b0;
            rsp_frame_err <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= req_a;
                        b_q     <= req_b;
                        cmd_q   <= req_cmd;
                        pkt     <= 4'd0;
                        bit_cnt <= 4'd0;
                    end
                end
                ST_TX: begin
                    if (bit_cnt == 4'd10) begin
                        bit_cnt <= 4'd0;
                        pkt     <= pkt + 4'd1;
                        gap_cnt <= GAP_LD;
                        tmo_cnt <= 16'd0;
                        rx_pkt  <= 3'd0;
                        acc     <= 32'h0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_GAP: gap_cnt <= gap_cnt - 4'd1;
                ST_RX_WAIT: begin
                    if (!sout) rx_cnt  <= 4'd0;
                    else       tmo_cnt <= tmo_cnt + 16'd1;
                end
                ST_RX_BIT: begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt != 4'd9) rx_sh <= {rx_sh[7:0], sout};
                    if (rx_cnt == 4'd9 && state_nxt == ST_RX_WAIT) begin
                        acc     <= {acc[23:0], rx_sh[7:0]};
                        rx_pkt  <= rx_pkt + 3'd1;
                        tmo_cnt <= 16'd0;
                    end
                end
                default: ;
            endcase
            if (ld_rsp) begin
                rsp_data      <= n_data;
                rsp_ctl       <= n_ctl;
                rsp_err       <= n_err;
                rsp_frame_err <= n_ferr;
                rsp_timeout   <= n_tmo;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl: vector table for whole transactions plus
// hand-written reset, timeout, frame-error and handshake sequences.
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'h0;
    logic [31:0] req_b = 32'h0;
    logic [7:0]  req_cmd = 8'h00;
    logic        sin;
    logic        sout = 1'b1;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_ctl;
    logic        rsp_err, rsp_frame_err, rsp_timeout;

    int total = 0;
    int bad   = 0;

    alu_serial_ctrl #(.GAP(1), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cmd(req_cmd), .sin(sin), .sout(sout),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ctl(rsp_ctl),
        .rsp_err(rsp_err), .rsp_frame_err(rsp_frame_err), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  cmd;
        logic        is_err;
        logic [31:0] rbytes;
        logic [7:0]  rcmd;
        logic [31:0] exp_data;
        logic [7:0]  exp_ctl;
        logic        exp_err;
    } vec_t;

    vec_t vecs [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Leaves req_valid high when keep is set; returns on the first TX cycle.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [7:0] cmd, input bit keep);
        int n;
        req_a = a; req_b = b; req_cmd = cmd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 500) begin
            tick;
            n++;
        end
        chk("accept_ready", {31'b0, req_ready}, 32'd1);
        tick;
        if (!keep) req_valid = 1'b0;
    endtask

    // Expects 9 packets of 11 bits with one idle-high bit between packets.
    task automatic check_tx(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cmd);
        logic exp_bits [107];
        logic [7:0]  byt;
        logic [10:0] fr;
        int idx, errs, rdy;
        idx = 0;
        for (int p = 0; p < 9; p++) begin
            if (p < 4)      byt = b[8*(3-p) +: 8];
            else if (p < 8) byt = a[8*(7-p) +: 8];
            else            byt = cmd;
            fr = {1'b0, (p == 8), byt, 1'b1};
            for (int k = 10; k >= 0; k--) begin
                exp_bits[idx] = fr[k];
                idx++;
            end
            if (p < 8) begin
                exp_bits[idx] = 1'b1;
                idx++;
            end
        end
        errs = 0;
        rdy  = 0;
        for (int i = 0; i < 107; i++) begin
            if (sin !== exp_bits[i]) errs++;
            if (req_ready) rdy++;
            tick;
        end
        chk("tx_stream_errs", errs, 0);
        chk("ready_during_tx", rdy, 0);
        chk("sin_idle_rx_wait", {31'b0, sin}, 32'd1);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] byt, input logic stop, input int idle);
        logic [10:0] bits;
        repeat (idle) tick;
        bits = {1'b0, typ, byt, stop};
        for (int i = 10; i >= 0; i--) begin
            sout = bits[i];
            tick;
        end
        sout = 1'b1;
    endtask

    task automatic check_rsp(input logic [31:0] data, input logic [7:0] ctl, input logic err,
                             input logic ferr, input logic tmo, input bit chk_data);
        chk("rsp_valid_hi", {31'b0, rsp_valid}, 32'd1);
        if (chk_data) begin
            chk("rsp_data", rsp_data, data);
            chk("rsp_ctl", {24'b0, rsp_ctl}, {24'b0, ctl});
        end
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        chk("rsp_frame_err", {31'b0, rsp_frame_err}, {31'b0, ferr});
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, tmo});
        tick;
        chk("rsp_valid_pulse", {31'b0, rsp_valid}, 32'd0);
        chk("ready_after_done", {31'b0, req_ready}, 32'd1);
        chk("rsp_err_hold", {31'b0, rsp_err}, {31'b0, err});
        if (chk_data) chk("rsp_data_hold", rsp_data, data);
    endtask

    task automatic respond(input vec_t v);
        if (v.is_err) begin
            send_pkt(1'b1, v.rcmd, 1'b1, 1);
        end else begin
            for (int k = 0; k < 4; k++)
                send_pkt(1'b0, v.rbytes[31-8*k -: 8], 1'b1, (k == 2) ? 3 : 0);
            send_pkt(1'b1, v.rcmd, 1'b1, 1);
        end
    endtask

    task automatic run_vec(input vec_t v);
        start_op(v.a, v.b, v.cmd, 1'b0);
        check_tx(v.a, v.b, v.cmd);
        respond(v);
        check_rsp(v.exp_data, v.exp_ctl, v.exp_err, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, nv, nlow;
        vec_t h1, h2;
        vecs[0] = '{32'h00000002, 32'h00000003, 8'h00, 1'b0, 32'h00000005, 8'h12,
                    32'h00000005, 8'h12, 1'b0};
        vecs[1] = '{32'h00000007, 32'h00000009, 8'h01, 1'b1, 32'h00000000, 8'hC9,
                    32'h00000000, 8'hC9, 1'b1};
        vecs[2] = '{32'hDEADBEEF, 32'h12345678, 8'hA5, 1'b0, 32'h11223344, 8'h80,
                    32'h11223344, 8'h80, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 8'hFF, 1'b0, 32'h80000001, 8'h00,
                    32'h80000001, 8'h00, 1'b0};

        // reset values while rst is held
        tick; tick;
        chk("rst_sin", {31'b0, sin}, 32'd1);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_data", rsp_data, 32'h0);
        chk("rst_ctl", {24'b0, rsp_ctl}, 32'h0);
        chk("rst_quals", {29'b0, rsp_err, rsp_frame_err, rsp_timeout}, 32'h0);
        rst = 1'b0;
        tick;
        chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // timeout: no start bit after TX, TIMEOUT = 50
        start_op(32'h1, 32'h2, 8'h33, 1'b0);
        check_tx(32'h1, 32'h2, 8'h33);
        k = 0;
        while (!rsp_valid && k < 200) begin
            tick;
            k++;
        end
        chk("timeout_cycles", k, 50);
        check_rsp(32'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

        // bad stop bit on the second response packet
        start_op(32'h4, 32'h5, 8'h06, 1'b0);
        check_tx(32'h4, 32'h5, 8'h06);
        send_pkt(1'b0, 8'h01, 1'b1, 0);
        send_pkt(1'b0, 8'h02, 1'b0, 1);
        check_rsp(32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // CMD after two DATA packets
        start_op(32'h8, 32'h9, 8'h0A, 1'b0);
        check_tx(32'h8, 32'h9, 8'h0A);
        send_pkt(1'b0, 8'hAA, 1'b1, 0);
        send_pkt(1'b0, 8'hBB, 1'b1, 0);
        send_pkt(1'b1, 8'hCC, 1'b1, 0);
        check_rsp(32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset inside the fifth packet
        start_op(32'hCAFEF00D, 32'h0BADBEEF, 8'h5A, 1'b0);
        repeat (50) tick;
        rst = 1'b1;
        tick;
        chk("midrst_sin", {31'b0, sin}, 32'd1);
        chk("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_ready", {31'b0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_rel", {31'b0, req_ready}, 32'd1);
        nv = 0;
        nlow = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) nv++;
            if (!sin) nlow++;
            tick;
        end
        chk("midrst_no_strobe", nv, 0);
        chk("midrst_sin_idle", nlow, 0);
        run_vec(vecs[0]);

        // req_valid held across two back-to-back operations
        h1 = vecs[2];
        h2 = vecs[3];
        start_op(h1.a, h1.b, h1.cmd, 1'b1);
        req_a = h2.a; req_b = h2.b; req_cmd = h2.cmd;
        check_tx(h1.a, h1.b, h1.cmd);
        respond(h1);
        chk("ready_at_done", {31'b0, req_ready}, 32'd0);
        check_rsp(h1.exp_data, h1.exp_ctl, h1.exp_err, 1'b0, 1'b0, 1'b1);
        tick;
        req_valid = 1'b0;
        check_tx(h2.a, h2.b, h2.cmd);
        respond(h2);
        check_rsp(h2.exp_data, h2.exp_ctl, h2.exp_err, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
